// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 GF(2^8) helpers, S-boxes, Rcon and key-schedule steps shared by the cipher blocks
package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_EXPAND,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } dec_state_t;

    // Index 0 and 11..15 are padding so a 4-bit counter can index directly.
    localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                         8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[8*(15 - x[3:0]) +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            default: row = 128'h172b047eba77d626e169146355210c7d;
        endcase
        return row[8*(15 - x[3:0]) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul02(input logic [7:0] b); return xtime(b);     endfunction
    function automatic logic [7:0] gmul03(input logic [7:0] b); return xtime(b) ^ b; endfunction
    function automatic logic [7:0] gmul09(input logic [7:0] b); return xtime(xtime(xtime(b))) ^ b; endfunction
    function automatic logic [7:0] gmul0b(input logic [7:0] b); return xtime(xtime(xtime(b))) ^ xtime(b) ^ b; endfunction
    function automatic logic [7:0] gmul0d(input logic [7:0] b); return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b; endfunction
    function automatic logic [7:0] gmul0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3),
                gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3),
                gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3),
                gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3)};
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_step_fwd(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = rk;
        w0 = w0 ^ sub_rot_word(w3) ^ {rcon, 24'h0};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one forward step: later words first, since w0 needs the recovered w3.
    function automatic logic [127:0] key_step_inv(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = rk;
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        w0 = w0 ^ sub_rot_word(w3) ^ {rcon, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/inv_cipher_round.sv
// rtl/inv_cipher_round.sv - one combinational AES inverse round; InvMixColumns bypassed on the last round
module inv_cipher_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] k,
    input  logic         last,
    output logic [127:0] st_nxt
);

    logic [127:0] sub_st;
    logic [127:0] keyed;

    // Byte r+4c is row r, column c; row r rotates right by r columns.
    always_comb begin
        sub_st = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_st[127 - 8*(r + 4*c) -: 8] = inv_sbox(st[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
            end
        end
    end

    assign keyed = sub_st ^ k;

    always_comb begin
        st_nxt = keyed;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                st_nxt[127 - 32*c -: 32] = inv_mix_column(keyed[127 - 32*c -: 32]);
            end
        end
    end

endmodule

// File: rtl/decryption_block.sv
// rtl/decryption_block.sv - iterative AES-128 inverse cipher with on-the-fly reverse key schedule
module decryption_block
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         decryptEnable,
    input  logic [127:0] key,
    input  logic [127:0] inputData,
    output logic [127:0] outputData,
    output logic         dataReady,
    output logic         busy
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    dec_state_t   state, state_nxt;
    logic [127:0] rk;
    logic [127:0] st;
    logic [3:0]   cnt;
    logic [127:0] k_inv;
    logic [127:0] round_out;

    assign k_inv = key_step_inv(rk, RCON[cnt]);

    inv_cipher_round u_round (
        .st     (st),
        .k      (k_inv),
        .last   (state == S_FINAL),
        .st_nxt (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        dataReady = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (decryptEnable) state_nxt = S_KEY_EXPAND;
            end
            S_KEY_EXPAND: if (cnt == LAST_RND) state_nxt = S_INIT;
            S_INIT:       state_nxt = S_ROUND;
            S_ROUND:      if (cnt == 4'd2) state_nxt = S_FINAL;
            S_FINAL:      state_nxt = S_DONE;
            S_DONE: begin
                dataReady = 1'b1;
                state_nxt = S_IDLE;
            end
            default:      state_nxt = S_IDLE;
        endcase
    end

    // The key is walked forward to round key 10, then back down to round key 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk         <= '0;
            st         <= '0;
            cnt        <= '0;
            outputData <= '0;
        end else begin
            case (state)
                S_IDLE: if (decryptEnable) begin
                    rk  <= key;
                    st  <= inputData;
                    cnt <= 4'd1;
                end
                S_KEY_EXPAND: begin
                    rk  <= key_step_fwd(rk, RCON[cnt]);
                    cnt <= cnt + 4'd1;
                end
                S_INIT: begin
                    st  <= st ^ rk;
                    cnt <= LAST_RND;
                end
                S_ROUND: begin
                    st  <= round_out;
                    rk  <= k_inv;
                    cnt <= cnt - 4'd1;
                end
                S_FINAL: outputData <= round_out;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/decryption_block.md
Name: decryption_block

Overview:
Iterative AES-128 inverse cipher (FIPS-197) and the receive-side counterpart of encryption_block. It takes a 128-bit ciphertext and the same 128-bit cipher key used for encryption, and returns the plaintext. One inverse round is computed per clock; the round keys are regenerated in reverse on the fly, so there is no round-key RAM. It sits beside encryption_block and shares its key/data conventions: byte 0 is bits [127:120], and the state is loaded column-major.

Parameters:
NUM_ROUNDS, 10, AES-128 round count; fixed, exposed only for the bench's latency arithmetic.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset; one clock; reset is asynchronous and active-high.
decryptEnable  input  1  start request, sampled in IDLE only.
key  input  128  cipher key (the original key, not the last round key).
inputData  input  128  ciphertext.
outputData  output  128  plaintext register.
dataReady  output  1  one-cycle pulse marking a new outputData.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE.
  - outputData=0, dataReady=0, busy=0.
  - Internal state, round-key and counter registers are cleared to 0.
  - Reset mid-operation aborts the block; no dataReady is produced.
- States: IDLE -> KEY_EXPAND -> INIT -> ROUND -> FINAL -> DONE -> IDLE.
- IDLE: on a rising edge with decryptEnable=1, latch key into rk, latch inputData into st, set cnt=1, go to KEY_EXPAND.
- KEY_EXPAND, 10 cycles, cnt=1..10:
  - rk <= forward key step(rk, Rcon[cnt]).
  - Leave after cnt=10; rk then holds round key 10.
- INIT, 1 cycle: st <= st ^ rk; cnt <= 10.
- Inverse key step (used in ROUND and FINAL):
  - Let w0..w3 be rk, with w0 = [127:96].
  - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[cnt],24'h0}.
- ROUND, 9 cycles, cnt=10..2:
  - Let k = inverse key step of rk with Rcon[cnt].
  - st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ k).
  - rk <= k; cnt decrements.
- FINAL, 1 cycle, cnt=1:
  - k = inverse key step of rk with Rcon[1]; k is round key 0 and must equal the latched key.
  - outputData <= InvSubBytes(InvShiftRows(st)) ^ k.
- DONE, 1 cycle: dataReady=1, then go to IDLE.
- Latency:
  - Capture edge E0; dataReady is high in the cycle after edge E21.
  - Request to result is 22 cycles, with busy high for 22 cycles.
  - Minimum spacing between starts is 23 cycles: DONE->IDLE takes 1 cycle, then the next capture.
- Held enable: if decryptEnable is still high in IDLE after DONE, a new decryption starts immediately with the current key and inputData.
- Input changes: changes to decryptEnable, key or inputData while busy=1 are ignored, because all inputs are latched at E0.
- outputData holds its last plaintext until the next FINAL writes it; it does not change during an operation.
- Arithmetic:
  - All operations are GF(2^8) with modulus 0x11B.
  - InvMixColumns coefficients are 0e, 0b, 0d, 09, built from xtime chains; no multipliers are inferred.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- The S-box and inverse S-box are combinational case functions; no memories are used.

Decomposition:
- Package aes_pkg, shared with encryption_block:
  - functions sbox, inv_sbox, xtime, gmul by fixed constants (09/0b/0d/0e/02/03);
  - the Rcon array;
  - function key_step_fwd(rk, rcon) and function key_step_inv(rk, rcon);
  - typedef enum for the decrypt FSM states.
- One combinational sub-module, inv_cipher_round:
  - inputs: st, k, and a last-round flag;
  - output: the next st;
  - when the last-round flag is set, InvMixColumns is bypassed.
- decryption_block itself holds the FSM, the counter and the registers.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, inputData=69c4e0d86a7b0430d8cdb78070b4c55a, decryptEnable pulse -> outputData=00112233445566778899aabbccddeeff; dataReady exactly one cycle, 22 cycles after the capture edge.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, inputData=3925841d02dc09fbdc118597196a0b32 -> outputData=3243f6a8885a308d313198a2e0370734.
- Loopback with encryption_block: key=5E74E7BA66B0C7CC1B7697B3F9F51527, inputData=deb0f81341f3503a7cd01e2bc7cdd556 -> outputData=7D8AE0F7CFA0A6CB09FB5D05A8EC586D; also run 100 random key/plaintext pairs through encryption_block then decryption_block and check identity.
- Input churn: start the C.1 case, then change key/inputData to random values and toggle decryptEnable every cycle while busy -> result is still 00112233445566778899aabbccddeeff; exactly one dataReady pulse.
- Back-to-back: hold decryptEnable=1 across two C.1/App. B operations -> dataReady pulses 23 cycles apart; outputData shows the C.1 plaintext, then the App. B plaintext.
- Reset mid-operation: assert rst asynchronously (not clock-aligned) at cycle 12 -> outputData=0, busy=0 and dataReady=0 immediately; after release, a fresh C.1 run passes.
